simd_run_ctrl: RTL and testbench

//  Run sequencer and vector-RAM port arbiter for the SIMD core (pe_top).

---
 rtl/simd_pkg.sv | 21 ++
 rtl/simd_run_ctrl_if.sv | 64 ++++++
 rtl/simd_ram_port_mux.sv | 54 +++++
 rtl/simd_run_ctrl.sv | 177 +++++++++++++++++
 tb/tb_simd_run_ctrl.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/simd_pkg.sv
// Shared types and constants for the SIMD run controller and its RAM port mux.
package simd_pkg;

    // Run sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } run_state_t;

    // Vector RAM indices as used on the ram_* port arrays and by host_sel
    localparam int RAM_A    = 0;
    localparam int RAM_B    = 1;
    localparam int RAM_RES  = 2;
    localparam int NUM_RAMS = 3;

    // host_sel encoding that selects no RAM
    localparam logic [1:0] SEL_ILLEGAL = 2'd3;

endpackage

// File: rtl/simd_run_ctrl_if.sv
// Host loader, pe_top and vector-RAM bus bundle around the run controller.
// The slave modport is the controller's view; master is the surrounding system.
interface simd_run_ctrl_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int PE_ELEMENTS = 4,
    parameter int DRAM_DEPTH  = 256
);
    localparam int VW = PE_ELEMENTS * DATA_WIDTH;
    localparam int AW = $clog2(DRAM_DEPTH);

    // host loader side
    logic [1:0]           host_sel;
    logic [AW-1:0]        host_addr;
    logic                 host_we;
    logic                 host_re;
    logic [VW-1:0]        host_wdata;
    logic [VW-1:0]        host_rdata;
    logic                 host_rvalid;
    logic                 host_err;

    // pe_top side
    logic                 core_rstn;
    logic                 core_valid;
    logic                 core_stop;
    logic                 core_a_re;
    logic                 core_b_re;
    logic [AW-1:0]        core_a_addr;
    logic [AW-1:0]        core_b_addr;
    logic [VW-1:0]        core_a_rdata;
    logic [VW-1:0]        core_b_rdata;
    logic                 core_r_we;
    logic [AW-1:0]        core_r_addr;
    logic [VW-1:0]        core_r_wdata;

    // vector BRAM side (index 0=A 1=B 2=RESULT)
    logic [2:0]           ram_re;
    logic [2:0]           ram_we;
    logic [2:0][AW-1:0]   ram_addr;
    logic [2:0][VW-1:0]   ram_wdata;
    logic [2:0][VW-1:0]   ram_rdata;

    modport slave (
        input  host_sel, host_addr, host_we, host_re, host_wdata,
        output host_rdata, host_rvalid, host_err,
        output core_rstn, core_valid,
        input  core_stop, core_a_re, core_b_re, core_a_addr, core_b_addr,
        output core_a_rdata, core_b_rdata,
        input  core_r_we, core_r_addr, core_r_wdata,
        output ram_re, ram_we, ram_addr, ram_wdata,
        input  ram_rdata
    );

    modport master (
        output host_sel, host_addr, host_we, host_re, host_wdata,
        input  host_rdata, host_rvalid, host_err,
        input  core_rstn, core_valid,
        output core_stop, core_a_re, core_b_re, core_a_addr, core_b_addr,
        input  core_a_rdata, core_b_rdata,
        output core_r_we, core_r_addr, core_r_wdata,
        input  ram_re, ram_we, ram_addr, ram_wdata,
        output ram_rdata
    );

endinterface

// File: rtl/simd_ram_port_mux.sv
// Combinational steering of the three vector RAM ports between host and core.
// While the core owns the RAMs, A/B are read-only and RESULT is write-only.
module simd_ram_port_mux
    import simd_pkg::*;
#(
    parameter int VW = 128,
    parameter int AW = 8
) (
    input  logic                core_own,
    input  logic                host_wr,
    input  logic                host_rd,
    input  logic [1:0]          host_sel,
    input  logic [AW-1:0]       host_addr,
    input  logic [VW-1:0]       host_wdata,
    input  logic                core_a_re,
    input  logic [AW-1:0]       core_a_addr,
    input  logic                core_b_re,
    input  logic [AW-1:0]       core_b_addr,
    input  logic                core_r_we,
    input  logic [AW-1:0]       core_r_addr,
    input  logic [VW-1:0]       core_r_wdata,
    output logic [2:0]          ram_re,
    output logic [2:0]          ram_we,
    output logic [2:0][AW-1:0]  ram_addr,
    output logic [2:0][VW-1:0]  ram_wdata
);

    // Route either the core's fixed port usage or the single host-selected RAM
    always_comb begin
        ram_re    = '0;
        ram_we    = '0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (core_own) begin
            ram_re[RAM_A]     = core_a_re;
            ram_addr[RAM_A]   = core_a_addr;
            ram_re[RAM_B]     = core_b_re;
            ram_addr[RAM_B]   = core_b_addr;
            ram_we[RAM_RES]   = core_r_we;
            ram_addr[RAM_RES] = core_r_addr;
            ram_wdata[RAM_RES] = core_r_wdata;
        end else begin
            for (int i = 0; i < NUM_RAMS; i++) begin
                if (host_sel == 2'(i)) begin
                    ram_re[i]    = host_rd;
                    ram_we[i]    = host_wr;
                    ram_addr[i]  = host_addr;
                    ram_wdata[i] = host_wdata;
                end
            end
        end
    end

endmodule

// File: rtl/simd_run_ctrl.sv
// Run sequencer and vector-RAM arbiter for pe_top: launches a run on start,
// waits for stop or timeout, drains final result writes, then hands the
// RAMs back to the host loader.
module simd_run_ctrl
    import simd_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int PE_ELEMENTS  = 4,
    parameter int DRAM_DEPTH   = 256,
    parameter int DRAIN_CYCLES = 2,
    parameter int CNT_W        = 24
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  timeout_max,
    output logic              busy,
    output logic              done,
    output logic              timed_out,
    output logic [CNT_W-1:0]  cycle_count,
    simd_run_ctrl_if.slave    bus
);

    localparam int VW = PE_ELEMENTS * DATA_WIDTH;
    localparam int AW = $clog2(DRAM_DEPTH);
    localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

    run_state_t  state;
    run_state_t  next_state;
    logic [3:0]  drain_cnt;
    logic        timed_out_q;
    logic        launch;
    logic        timeout_hit;
    logic        core_own;
    logic        host_own;
    logic        host_acc;
    logic        host_wr;
    logic        host_rd;
    logic        host_rej;
    logic        rvalid_q;
    logic [1:0]  rsel_q;
    logic        err_q;

    assign launch      = (state == IDLE || state == DONE) && start && !abort;
    assign timeout_hit = (timeout_max != '0) && (cycle_count == timeout_max - 1'b1);

    // State register
    always_ff @(posedge clk) begin
        if (!rstn) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state logic; abort overrides everything else
    always_comb begin
        next_state = state;
        if (abort) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE, DONE: if (start) next_state = RUN;
                RUN:        if (core_stop_or_timeout()) next_state = DRAIN;
                DRAIN:      if (drain_cnt == DRAIN_LAST) next_state = DONE;
                default:    next_state = IDLE;
            endcase
        end
    end

    function automatic logic core_stop_or_timeout();
        return bus.core_stop || timeout_hit;
    endfunction

    // State-decoded outputs and RAM ownership
    always_comb begin
        busy           = 1'b0;
        done           = 1'b0;
        bus.core_rstn  = 1'b0;
        bus.core_valid = 1'b0;
        core_own       = 1'b0;
        host_own       = 1'b0;
        case (state)
            RUN: begin
                busy = 1'b1; bus.core_rstn = 1'b1; bus.core_valid = 1'b1; core_own = 1'b1;
            end
            DRAIN: begin
                busy = 1'b1; bus.core_rstn = 1'b1; core_own = 1'b1;
            end
            DONE: begin
                done = 1'b1; host_own = 1'b1;
            end
            default: host_own = 1'b1;
        endcase
    end

    assign timed_out = timed_out_q && (state == DONE);

    // Run-length counter, drain timer and timeout flag
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cycle_count <= '0;
            drain_cnt   <= '0;
            timed_out_q <= 1'b0;
        end else begin
            if (launch)             cycle_count <= '0;
            else if (state == RUN)  cycle_count <= cycle_count + 1'b1;

            if (state == DRAIN) drain_cnt <= drain_cnt + 1'b1;
            else                drain_cnt <= '0;

            if (launch)
                timed_out_q <= 1'b0;
            else if (state == RUN && timeout_hit && !abort)
                timed_out_q <= 1'b1;
        end
    end

    // Host access qualification: write beats read, illegal select or busy rejects
    assign host_acc = host_own && (bus.host_sel != SEL_ILLEGAL);
    assign host_wr  = bus.host_we && host_acc;
    assign host_rd  = bus.host_re && !bus.host_we && host_acc;
    assign host_rej = (bus.host_we || bus.host_re) && !host_acc;

    // Read-return tracking and error pulse, aligned with the 1-cycle BRAM latency
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rvalid_q <= 1'b0;
            rsel_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            rvalid_q <= host_rd;
            if (host_rd) rsel_q <= bus.host_sel;
            err_q    <= host_rej;
        end
    end

    // Return data from whichever RAM the read was issued to
    always_comb begin
        bus.host_rdata = '0;
        if (rvalid_q) begin
            case (rsel_q)
                2'd0:    bus.host_rdata = bus.ram_rdata[RAM_A];
                2'd1:    bus.host_rdata = bus.ram_rdata[RAM_B];
                2'd2:    bus.host_rdata = bus.ram_rdata[RAM_RES];
                default: bus.host_rdata = '0;
            endcase
        end
    end

    assign bus.host_rvalid  = rvalid_q;
    assign bus.host_err     = err_q;
    assign bus.core_a_rdata = bus.ram_rdata[RAM_A];
    assign bus.core_b_rdata = bus.ram_rdata[RAM_B];

    simd_ram_port_mux #(
        .VW (VW),
        .AW (AW)
    ) u_mux (
        .core_own     (core_own),
        .host_wr      (host_wr),
        .host_rd      (host_rd),
        .host_sel     (bus.host_sel),
        .host_addr    (bus.host_addr),
        .host_wdata   (bus.host_wdata),
        .core_a_re    (bus.core_a_re),
        .core_a_addr  (bus.core_a_addr),
        .core_b_re    (bus.core_b_re),
        .core_b_addr  (bus.core_b_addr),
        .core_r_we    (bus.core_r_we),
        .core_r_addr  (bus.core_r_addr),
        .core_r_wdata (bus.core_r_wdata),
        .ram_re       (bus.ram_re),
        .ram_we       (bus.ram_we),
        .ram_addr     (bus.ram_addr),
        .ram_wdata    (bus.ram_wdata)
    );

endmodule

// File: tb/tb_simd_run_ctrl.sv
// Directed bench for simd_run_ctrl with behavioural 1-cycle-latency vector RAMs.
module tb_simd_run_ctrl;
    import simd_pkg::*;

    localparam int CNT_W = 24;

    logic              clk = 1'b0;
    logic              rstn;
    logic              start;
    logic              abort;
    logic [CNT_W-1:0]  timeout_max;
    logic              busy;
    logic              done;
    logic              timed_out;
    logic [CNT_W-1:0]  cycle_count;

    int n_cmp  = 0;
    int n_fail = 0;
    int busy_cyc;
    logic r_written;

    logic [127:0] mem [3][256];

    localparam logic [127:0] DATA_X = 128'h0123_4567_89ab_cdef_0011_2233_4455_6677;
    localparam logic [127:0] DATA_Y = 128'hdead_beef_cafe_f00d_1357_9bdf_2468_ace0;
    localparam logic [127:0] DATA_Z = 128'h5555_aaaa_5555_aaaa_0f0f_f0f0_3c3c_c3c3;

    simd_run_ctrl_if #(.DATA_WIDTH(32), .PE_ELEMENTS(4), .DRAM_DEPTH(256)) bus ();

    simd_run_ctrl #(
        .DATA_WIDTH   (32),
        .PE_ELEMENTS  (4),
        .DRAM_DEPTH   (256),
        .DRAIN_CYCLES (2),
        .CNT_W        (CNT_W)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .start       (start),
        .abort       (abort),
        .timeout_max (timeout_max),
        .busy        (busy),
        .done        (done),
        .timed_out   (timed_out),
        .cycle_count (cycle_count),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    // Behavioural vector BRAMs, one cycle read latency
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (bus.ram_we[i]) mem[i][bus.ram_addr[i]] <= bus.ram_wdata[i];
            if (bus.ram_re[i]) bus.ram_rdata[i] <= mem[i][bus.ram_addr[i]];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rstn = 1'b0; start = 1'b0; abort = 1'b0; timeout_max = '0;
        bus.host_sel = 2'd0; bus.host_addr = '0; bus.host_we = 1'b0; bus.host_re = 1'b0;
        bus.host_wdata = '0; bus.core_stop = 1'b0; bus.core_a_re = 1'b0; bus.core_b_re = 1'b0;
        bus.core_a_addr = '0; bus.core_b_addr = '0; bus.core_r_we = 1'b0;
        bus.core_r_addr = '0; bus.core_r_wdata = '0;
        tick(); tick();

        // reset state
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_core_rstn", bus.core_rstn, 0);
        check("rst_core_valid", bus.core_valid, 0);
        check("rst_cycle_count", cycle_count, 0);
        check("rst_rvalid", bus.host_rvalid, 0);
        check("rst_err", bus.host_err, 0);
        rstn = 1'b1;
        tick();

        // host write A[5]=X then read back
        bus.host_sel = 2'd0; bus.host_addr = 8'd5; bus.host_we = 1'b1; bus.host_wdata = DATA_X;
        #1 check("hwr_ram_we", bus.ram_we, 3'b001);
        tick();
        bus.host_we = 1'b0; bus.host_re = 1'b1;
        tick();
        bus.host_re = 1'b0;
        check("hrd_rvalid", bus.host_rvalid, 1);
        check("hrd_rdata", bus.host_rdata, DATA_X);
        check("hrd_err", bus.host_err, 0);
        tick();
        check("hrd_rvalid_drop", bus.host_rvalid, 0);

        // illegal select
        bus.host_sel = 2'd3; bus.host_we = 1'b1;
        #1 check("sel3_ram_we", bus.ram_we, 3'b000);
        tick();
        bus.host_we = 1'b0; bus.host_sel = 2'd0;
        check("sel3_err", bus.host_err, 1);
        tick();
        check("sel3_err_once", bus.host_err, 0);

        // run stopped by core after 40 RUN cycles, with a RESULT write in DRAIN
        start = 1'b1;
        tick();
        start = 1'b0;
        check("run_core_rstn", bus.core_rstn, 1);
        check("run_core_valid", bus.core_valid, 1);
        busy_cyc = 0;
        r_written = 1'b0;
        for (int i = 0; i < 100 && busy; i++) begin
            busy_cyc++;
            bus.core_r_we = 1'b0;
            if (!bus.core_valid && !r_written) begin
                bus.core_r_we = 1'b1; bus.core_r_addr = 8'd7; bus.core_r_wdata = DATA_Y;
                r_written = 1'b1;
            end
            bus.core_stop = bus.core_valid && (cycle_count == 24'd39);
            tick();
        end
        bus.core_stop = 1'b0; bus.core_r_we = 1'b0;
        check("stop_busy_cycles", busy_cyc, 42);
        check("stop_done", done, 1);
        check("stop_cycle_count", cycle_count, 40);
        check("stop_timed_out", timed_out, 0);
        check("stop_core_rstn", bus.core_rstn, 0);

        // host reads RESULT[7] in DONE
        bus.host_sel = 2'd2; bus.host_addr = 8'd7; bus.host_re = 1'b1;
        tick();
        bus.host_re = 1'b0;
        check("res_rvalid", bus.host_rvalid, 1);
        check("res_rdata", bus.host_rdata, DATA_Y);

        // write and read together: write wins, no read issued
        bus.host_sel = 2'd0; bus.host_addr = 8'd5; bus.host_we = 1'b1; bus.host_re = 1'b1;
        bus.host_wdata = DATA_Z;
        #1 check("wr_rd_ram_re", bus.ram_re, 3'b000);
        check("wr_rd_ram_we", bus.ram_we, 3'b001);
        tick();
        bus.host_we = 1'b0; bus.host_re = 1'b0;
        check("wr_rd_no_rvalid", bus.host_rvalid, 0);

        // timeout run from DONE, with a rejected host write while busy
        timeout_max = 24'd10;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("to_done_cleared", done, 0);
        check("to_count_cleared", cycle_count, 0);
        bus.host_sel = 2'd0; bus.host_addr = 8'd9; bus.host_we = 1'b1;
        #1 check("busy_ram_we", bus.ram_we, 3'b000);
        tick();
        bus.host_we = 1'b0;
        check("busy_err", bus.host_err, 1);
        for (int i = 0; i < 50 && !done; i++) tick();
        check("to_done", done, 1);
        check("to_timed_out", timed_out, 1);
        check("to_cycle_count", cycle_count, 10);

        // abort together with core_stop mid-RUN
        timeout_max = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        bus.core_stop = 1'b1; abort = 1'b1;
        tick();
        bus.core_stop = 1'b0; abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_core_rstn", bus.core_rstn, 0);
        check("abort_cycle_count", cycle_count, 6);
        bus.core_r_we = 1'b1; bus.core_r_addr = 8'd3;
        #1 check("abort_core_we_blocked", bus.ram_we, 3'b000);
        bus.core_r_we = 1'b0;
        tick();
        check("abort_idle_stays", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
